// File: rtl/id_ex_if.sv
// id_ex_if: decode-to-execute bundle; master is the decode/hazard side, slave is the pipeline register.
interface id_ex_if #(
   parameter int WIDTH = 32,
   parameter int REG_ADDR_W = 5
);
   logic StallE, FlushE, ValidD;
   logic [WIDTH-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
   logic [REG_ADDR_W-1:0] Rs1D, Rs2D, RdD;
   logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
   logic [1:0] ResultSrcD;
   logic [3:0] ALUControlD;
   logic [WIDTH-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
   logic [REG_ADDR_W-1:0] Rs1E, Rs2E, RdE;
   logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
   logic [1:0] ResultSrcE;
   logic [3:0] ALUControlE;
   logic [31:0] BubbleCountE;
   modport master (
      output StallE, FlushE, ValidD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
             RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
      input  RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, RegWriteE, MemWriteE,
             JumpE, BranchE, ALUSrcE, ValidE, ResultSrcE, ALUControlE, BubbleCountE
   );
   modport slave (
      input  StallE, FlushE, ValidD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
             RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
      output RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, RegWriteE, MemWriteE,
             JumpE, BranchE, ALUSrcE, ValidE, ResultSrcE, ALUControlE, BubbleCountE
   );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: D-to-E pipeline register with stall hold and flush bubbles.
// Define ID_EX_BUBBLE_CNT_EN to build the 32-bit bubble counter; otherwise BubbleCountE is 0.
module id_ex_pipe_reg #(
   parameter int WIDTH = 32,
   parameter int REG_ADDR_W = 5
) (
   input logic clk,
   input logic rst,
   id_ex_if.slave bus
);
   // reset and flush both leave an all-zero bubble; stall simply keeps the flops
   always_ff @(posedge clk)
      if (rst || bus.FlushE) begin
         bus.RD1E <= {WIDTH{1'b0}};
         bus.RD2E <= {WIDTH{1'b0}};
         bus.PCE <= {WIDTH{1'b0}};
         bus.PCPlus4E <= {WIDTH{1'b0}};
         bus.ImmExtE <= {WIDTH{1'b0}};
         bus.Rs1E <= {REG_ADDR_W{1'b0}};
         bus.Rs2E <= {REG_ADDR_W{1'b0}};
         bus.RdE <= {REG_ADDR_W{1'b0}};
         bus.RegWriteE <= 1'b0;
         bus.ResultSrcE <= 2'b00;
         bus.MemWriteE <= 1'b0;
         bus.JumpE <= 1'b0;
         bus.BranchE <= 1'b0;
         bus.ALUControlE <= 4'h0;
         bus.ALUSrcE <= 1'b0;
         bus.ValidE <= 1'b0;
      end else if (!bus.StallE) begin
         bus.RD1E <= bus.RD1D;
         bus.RD2E <= bus.RD2D;
         bus.PCE <= bus.PCD;
         bus.PCPlus4E <= bus.PCPlus4D;
         bus.ImmExtE <= bus.ImmExtD;
         bus.Rs1E <= bus.Rs1D;
         bus.Rs2E <= bus.Rs2D;
         bus.RdE <= bus.RdD;
         bus.RegWriteE <= bus.RegWriteD;
         bus.ResultSrcE <= bus.ResultSrcD;
         bus.MemWriteE <= bus.MemWriteD;
         bus.JumpE <= bus.JumpD;
         bus.BranchE <= bus.BranchD;
         bus.ALUControlE <= bus.ALUControlD;
         bus.ALUSrcE <= bus.ALUSrcD;
         bus.ValidE <= bus.ValidD;
      end
`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt;
   always_ff @(posedge clk)
      if (rst) bubble_cnt <= 32'd0;
      else if (bus.FlushE) bubble_cnt <= bubble_cnt + 32'd1;
   assign bus.BubbleCountE = bubble_cnt;
`else
   assign bus.BubbleCountE = 32'd0;
`endif
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Decode-to-execute pipeline register of the pipelined RV32I core.
- Captures the register-file read data, immediate, PC values, register addresses and decoded control from decode (D). Presents them to execute (E) one cycle later.
- RD1E/RD2E feed the execute-stage forwarding muxes. Rs1E/Rs2E/RdE feed the hazard unit.
- Implements hold (stall) and bubble-insertion (flush) so the hazard unit can resolve load-use and control hazards.

Parameters:
- WIDTH, 32, data/address datapath width.
- REG_ADDR_W, 5, register-file index width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- StallE  input  1  hold current E-stage contents.
- FlushE  input  1  load a bubble into E stage.
- ValidD  input  1  decode slot holds a real instruction.
- RD1D  input  WIDTH  register-file read port 1 data.
- RD2D  input  WIDTH  register-file read port 2 data.
- PCD  input  WIDTH  decode-stage PC.
- PCPlus4D  input  WIDTH  PC+4 of decode instruction.
- ImmExtD  input  WIDTH  sign-extended immediate.
- Rs1D  input  REG_ADDR_W  source register 1 index.
- Rs2D  input  REG_ADDR_W  source register 2 index.
- RdD  input  REG_ADDR_W  destination register index.
- RegWriteD  input  1  register write enable.
- ResultSrcD  input  2  writeback result select.
- MemWriteD  input  1  data-memory write enable.
- JumpD  input  1  jump instruction.
- BranchD  input  1  branch instruction.
- ALUControlD  input  4  ALU operation.
- ALUSrcD  input  1  ALU B operand select (immediate).
- RD1E, RD2E, PCE, PCPlus4E, ImmExtE  output  WIDTH  registered copies.
- Rs1E, Rs2E, RdE  output  REG_ADDR_W  registered copies.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  output  1  registered control.
- ResultSrcE  output  2  registered control.
- ALUControlE  output  4  registered control.
- ValidE  output  1  E-stage slot holds a real instruction.
- BubbleCountE  output  32  count of bubbles inserted (see Optional Feature).

Behaviour:
- One clock; reset is synchronous and active-high. Port names: clk, rst.
- All outputs are registered. D-to-E latency is exactly 1 cycle. No combinational path from any input to any output.
- Per-edge priority: rst > FlushE > StallE > normal load.
- rst asserted at an edge: every output becomes 0, including ValidE=0 and BubbleCountE=0. Reset asserted mid-stall or mid-flush still clears everything at that edge.
- FlushE=1 (rst=0) produces a bubble:
  - All outputs are loaded with 0 except BubbleCountE.
  - RdE=0, so no forwarding match is possible.
  - RegWriteE=0 and MemWriteE=0, so no architectural side effect.
  - ValidE=0.
  - FlushE overrides a simultaneous StallE.
- StallE=1, FlushE=0: all outputs retain their previous values, including ValidE. D inputs are ignored.
- Normal load (StallE=0, FlushE=0): every E output takes the corresponding D input; ValidE<=ValidD.
- ValidD=0 on a normal load: fields are still captured verbatim; only ValidE=0 marks the slot. Decode is responsible for driving zero control on invalid slots.
- No internal arithmetic apart from the optional counter.
- Counter width is fixed at 32 bits and wraps 0xFFFFFFFF -> 0 silently.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined:
  - BubbleCountE increments by 1 on each edge where rst=0 and FlushE=1, regardless of StallE.
  - It holds otherwise, clears on rst, and wraps modulo 2^32.
  - The value is visible on the cycle after the flushing edge.
- Undefined: BubbleCountE is tied to constant 0 and no counter flops are synthesised. All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with D inputs driven to 0xFFFFFFFF / all-ones -> all E outputs 0, ValidE=0; first edge after rst=0 with RD2D=0x12345678 -> RD2E=0x12345678 next cycle.
- Pass-through: stream PCD=0x0,0x4,0x8 with ValidD=1, no stall/flush -> PCE follows one cycle behind (0x0,0x4,0x8), ValidE=1 each cycle.
- Stall hold: load RdD=5, RegWriteD=1, then StallE=1 for 3 cycles while RdD=7 -> RdE stays 5, RegWriteE stays 1; after release RdE=7.
- Flush/stall collision: E holds RdE=3, MemWriteE=1; assert FlushE=1 and StallE=1 together -> next cycle RdE=0, MemWriteE=0, RegWriteE=0, ValidE=0.
- Load-use pattern: FlushE=1 for one cycle between two instructions -> exactly one bubble (ValidE=0) between them; with ID_EX_BUBBLE_CNT_EN defined, BubbleCountE goes 0->1, and it stays 0 when undefined.
- Counter wrap (macro defined): force counter to 0xFFFFFFFF, one flush -> BubbleCountE=0x00000000; rst during a flush -> BubbleCountE=0.
